// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU ops,
// mux selects, FSM states and the registered control-word decode.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_FUNC = 3'b010;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  // Pure state-decoded part of the control word. The in_* flags let the top
  // build the few strobes that also depend on mem_ready / zero.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       in_fetch;
    logic       in_branch;
    logic       in_jump;
  } ctrl_t;

  function automatic ctrl_t moore_decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        c.in_fetch  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_SEXT_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNC;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_SEXT;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEM_WR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_WB_I: c.reg_write = 1'b1;
      S_WB_MEM: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_SUB;
        c.pc_source = PCSRC_ALUOUT;
        c.in_branch = 1'b1;
      end
      S_JUMP: begin
        c.pc_source = PCSRC_JUMP;
        c.in_jump   = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decode: which state follows DECODE, and whether the opcode is illegal.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output state_t     next_state,
  output logic       illegal
);

  // Map the instruction class onto its first execution state.
  always_comb begin
    next_state = S_HALT;
    illegal    = 1'b0;
    case (opcode)
      OP_RTYPE:      next_state = S_EXEC_R;
      OP_LW, OP_SW:  next_state = S_MEM_ADDR;
      OP_BEQ:        next_state = S_BRANCH;
      OP_ADDI:       next_state = S_EXEC_I;
      OP_J:          next_state = S_JUMP;
      default:       illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller: FSM, registered control word,
// memory-ready handshake, illegal-opcode halt and retire counter.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             halted,
  output logic [CNT_W-1:0] retire_count
);

  state_t state, next_state, dec_next;
  logic   dec_illegal;
  logic   retire;
  ctrl_t  ctl;

  ctrl_decode u_decode (
    .opcode     (opcode),
    .next_state (dec_next),
    .illegal    (dec_illegal)
  );

  // Next-state selection and retire detection (an instruction retires on
  // the edge that leaves its last state back to FETCH).
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_RESET:    next_state = S_FETCH;
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE:   next_state = dec_illegal ? S_HALT : dec_next;
      S_EXEC_R:   next_state = S_WB_R;
      S_EXEC_I:   next_state = S_WB_I;
      S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) next_state = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_RESET;
    endcase
  end

  // State, registered control word (decoded from the incoming state so it
  // lines up with it) and retire counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_RESET;
      ctl          <= '0;
      retire_count <= '0;
    end else begin
      state <= next_state;
      ctl   <= moore_decode(next_state);
      if (retire) retire_count <= retire_count + CNT_W'(1);
    end
  end

  assign iord       = ctl.iord;
  assign mem_read   = ctl.mem_read;
  assign mem_write  = ctl.mem_write;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;
  assign reg_write  = ctl.reg_write;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign pc_source  = ctl.pc_source;
  assign halted     = ctl.halted;

  // Fetch loads IR and PC+4 only on the cycle memory delivers; beq writes
  // the PC only when the compare is equal.
  assign ir_write = ctl.in_fetch & mem_ready;
  assign pc_write = (ctl.in_fetch & mem_ready) | (ctl.in_branch & zero) | ctl.in_jump;

endmodule
